// File: rtl/aes_wb_dma_pkg.sv
// CSR register map, FSM encoding and address helper shared by the aes_wb_dma copy engine.
package aes_wb_dma_pkg;

  localparam logic [9:0] CSR_STAT = 10'd0;
  localparam logic [9:0] CSR_CTRL = 10'd1;
  localparam logic [9:0] CSR_SRC  = 10'd2;
  localparam logic [9:0] CSR_DST  = 10'd3;
  localparam logic [9:0] CSR_LEN  = 10'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WAIT_W = 3'd2,
    ST_WR     = 3'd3,
    ST_WAIT_R = 3'd4
  } state_t;

  // Byte address of word idx past base; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [10:0] idx);
    return base + {19'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/aes_wb_dma.sv
// Wishbone master copy engine: one 32-bit word per 6 cycles against a 1-cycle-ack slave.
// Slave wait states stretch RD/WR without limit; CSR reads return data one cycle after csr_a.
module aes_wb_dma
  import aes_wb_dma_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i,
  output logic        irq
);

  state_t      state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic [31:0] dat_q, dat_d;
  logic [29:0] src_q, src_d;
  logic [29:0] dst_q, dst_d;
  logic [10:0] len_q, len_d;
  logic        irq_en_q, irq_en_d;
  logic        event_end_q, event_end_d;
  logic        aborted_q, aborted_d;
  logic        abort_pend_q, abort_pend_d;
  logic        start_q, start_d;
  logic [31:0] csr_do_q, csr_do_d;

  logic csr_sel;
  logic csr_wr;
  logic busy;
  logic last_word;
  logic xfer_done;

  assign csr_sel   = (csr_a[13:10] == csr_addr);
  assign csr_wr    = csr_sel & csr_we;
  assign busy      = (state_q != ST_IDLE);
  assign last_word = (({1'b0, idx_q} + 12'd1) == {1'b0, len_q});

  // Completion covers both the empty start and the final (or aborted) write ack.
  assign xfer_done = (state_q == ST_IDLE && start_q && len_q == '0)
                   || (state_q == ST_WR && wb_ack_i && (last_word || abort_pend_q));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_q && len_q != '0) begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (wb_ack_i) begin
          state_d = ST_WAIT_W;
        end
      end
      ST_WAIT_W: state_d = ST_WR;
      ST_WR: begin
        if (wb_ack_i) begin
          state_d = (last_word || abort_pend_q) ? ST_IDLE : ST_WAIT_R;
        end
      end
      ST_WAIT_R: state_d = ST_RD;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    case (state_q)
      ST_RD: begin
        wb_stb_o = 1'b1;
        wb_adr_o = word_addr({src_q, 2'b00}, idx_q);
      end
      ST_WR: begin
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = word_addr({dst_q, 2'b00}, idx_q);
        wb_dat_o = dat_q;
      end
      default: ;
    endcase
  end

  assign wb_cyc_o = wb_stb_o;
  assign wb_sel_o = {4{wb_stb_o}};
  assign irq      = irq_en_q & event_end_q;
  assign csr_do   = csr_do_q;

  always_comb begin
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    irq_en_d     = irq_en_q;
    idx_d        = idx_q;
    dat_d        = dat_q;
    start_d      = 1'b0;
    abort_pend_d = abort_pend_q;
    event_end_d  = event_end_q;
    aborted_d    = aborted_q;

    if (csr_wr && !busy) begin
      case (csr_a[9:0])
        CSR_SRC: src_d = csr_di[31:2];
        CSR_DST: dst_d = csr_di[31:2];
        CSR_LEN: len_d = csr_di[10:0];
        default: ;
      endcase
    end

    if (csr_wr && csr_a[9:0] == CSR_CTRL) begin
      irq_en_d = csr_di[0];
      if (!busy) begin
        start_d = csr_di[1];
      end else if (csr_di[2]) begin
        abort_pend_d = 1'b1;
      end
    end

    if (csr_wr && csr_a[9:0] == CSR_STAT) begin
      if (csr_di[0]) event_end_d = 1'b0;
      if (csr_di[2]) aborted_d = 1'b0;
    end

    if (state_q == ST_IDLE && start_q) idx_d = '0;
    if (state_q == ST_RD && wb_ack_i) dat_d = wb_dat_i;
    if (state_q == ST_WR && wb_ack_i) idx_d = idx_q + 11'd1;

    // Placed after the W1C handling so a completion in the same cycle wins.
    if (xfer_done) begin
      event_end_d  = 1'b1;
      abort_pend_d = 1'b0;
      if (abort_pend_q) aborted_d = 1'b1;
    end
  end

  always_comb begin
    csr_do_d = '0;
    if (csr_sel) begin
      case (csr_a[9:0])
        CSR_STAT: csr_do_d = {29'b0, aborted_q, busy, event_end_q};
        CSR_CTRL: csr_do_d = {31'b0, irq_en_q};
        CSR_SRC:  csr_do_d = {src_q, 2'b00};
        CSR_DST:  csr_do_d = {dst_q, 2'b00};
        CSR_LEN:  csr_do_d = {21'b0, len_q};
        default:  csr_do_d = '0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx_q        <= '0;
      dat_q        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      irq_en_q     <= 1'b0;
      event_end_q  <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      start_q      <= 1'b0;
      csr_do_q     <= '0;
    end else begin
      idx_q        <= idx_d;
      dat_q        <= dat_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      irq_en_q     <= irq_en_d;
      event_end_q  <= event_end_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      start_q      <= start_d;
      csr_do_q     <= csr_do_d;
    end
  end

endmodule

// File: tb/tb_aes_wb_dma.sv
// Bench for aes_wb_dma: CSR vector table, directed corner sequences and randomized copies
// checked against a word-by-word memory copy model.
module tb_aes_wb_dma;
  import aes_wb_dma_pkg::*;

  localparam logic [3:0] BANK = 4'h3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_we_o;
  logic        wb_ack_i = 1'b0;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  aes_wb_dma #(.csr_addr(BANK)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_we_o(wb_we_o), .wb_ack_i(wb_ack_i), .irq(irq)
  );

  // Slave memory and access log
  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  int          log_cyc[$];
  int ws = 0;
  int wcnt = 0;
  int stb_cycles = 0;
  int early_drop = 0;
  int cyc_cnt = 0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  always @(posedge sys_clk) cyc_cnt++;

  // Ack is raised at a negedge so it spans exactly one rising edge; ws extra wait cycles.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      wb_ack_i = 1'b0;
      wcnt = 0;
    end else if (wb_ack_i) begin
      wb_ack_i = 1'b0;
      wcnt = 0;
    end else if (wb_stb_o) begin
      stb_cycles++;
      if (wcnt == ws + 1) begin
        wb_ack_i = 1'b1;
        log_adr.push_back(wb_adr_o);
        log_we.push_back(wb_we_o);
        log_cyc.push_back(cyc_cnt);
        if (wb_we_o) begin
          mem[wb_adr_o] = wb_dat_o;
          log_dat.push_back(wb_dat_o);
        end else begin
          wb_dat_i = rd_mem(wb_adr_o);
          log_dat.push_back(wb_dat_i);
        end
      end else begin
        wcnt++;
      end
    end else if (wcnt != 0) begin
      early_drop++;
    end
  end

  // Reference model: sequential word copy over a snapshot of memory
  logic [31:0] mm [logic [31:0]];
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic        exp_we[$];

  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return mm.exists(a) ? mm[a] : ~a;
  endfunction

  task automatic prep_model(input logic [31:0] s, input logic [31:0] d, input int n);
    logic [31:0] v;
    mm = mem;
    exp_adr.delete(); exp_dat.delete(); exp_we.delete();
    for (int k = 0; k < n; k++) begin
      v = mm_rd(s + 32'(4 * k));
      exp_adr.push_back(s + 32'(4 * k)); exp_we.push_back(1'b0); exp_dat.push_back(v);
      exp_adr.push_back(d + 32'(4 * k)); exp_we.push_back(1'b1); exp_dat.push_back(v);
      mm[d + 32'(4 * k)] = v;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [9:0] r, input logic [31:0] d);
    @(negedge sys_clk);
    csr_a = {BANK, r}; csr_di = d; csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [9:0] r, output logic [31:0] d);
    @(negedge sys_clk);
    csr_a = {BANK, r}; csr_we = 1'b0;
    @(negedge sys_clk);
    d = csr_do;
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] s;
    int n;
    repeat (2) @(negedge sys_clk);
    for (n = 0; n < 3000; n++) begin
      csr_rd(CSR_STAT, s);
      if (!s[1]) break;
    end
    chk({nm, " finished"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic fill(input logic [31:0] base, input int cnt);
    for (int k = 0; k < cnt; k++) mem[base + 32'(4 * k)] = $urandom;
  endtask

  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input int n, input int w);
    ws = w;
    log_adr.delete(); log_we.delete(); log_dat.delete(); log_cyc.delete();
    csr_wr(CSR_STAT, 32'h5);
    csr_wr(CSR_SRC, s);
    csr_wr(CSR_DST, d);
    csr_wr(CSR_LEN, 32'(n));
    csr_wr(CSR_CTRL, 32'h3);
  endtask

  task automatic cmp_run(input string nm, input logic [31:0] d, input int span);
    chk({nm, " log size"}, 32'(log_adr.size()), 32'(exp_adr.size()));
    for (int i = 0; i < exp_adr.size() && i < log_adr.size(); i++) begin
      chk($sformatf("%s acc%0d adr", nm, i), log_adr[i], exp_adr[i]);
      chk($sformatf("%s acc%0d we", nm, i), {31'b0, log_we[i]}, {31'b0, exp_we[i]});
      chk($sformatf("%s acc%0d dat", nm, i), log_dat[i], exp_dat[i]);
    end
    for (int k = 0; k < span; k++)
      chk($sformatf("%s dst%0d", nm, k), rd_mem(d + 32'(4 * k)), mm_rd(d + 32'(4 * k)));
  endtask

  typedef struct {
    logic [9:0]  r;
    logic [31:0] wd;
    logic [31:0] exp;
  } csr_vec_t;

  initial begin
    csr_vec_t    tbl[9];
    logic [31:0] rv;
    logic [31:0] s, d;
    int          first_stb, irq_at, n, w;
    bit          found;

    tbl[0] = '{CSR_SRC,  32'h12345677, 32'h12345674};
    tbl[1] = '{CSR_DST,  32'hFFFFFFFF, 32'hFFFFFFFC};
    tbl[2] = '{CSR_LEN,  32'hFFFFFFFF, 32'h000007FF};
    tbl[3] = '{CSR_LEN,  32'h00000803, 32'h00000003};
    tbl[4] = '{CSR_CTRL, 32'hFFFFFFF9, 32'h00000001};
    tbl[5] = '{CSR_CTRL, 32'h00000000, 32'h00000000};
    tbl[6] = '{CSR_STAT, 32'hFFFFFFFF, 32'h00000000};
    tbl[7] = '{10'd5,    32'hFFFFFFFF, 32'h00000000};
    tbl[8] = '{10'h3FF,  32'hFFFFFFFF, 32'h00000000};

    // Reset state
    #2 sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("rst stb", {31'b0, wb_stb_o}, 32'd0);
    chk("rst cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("rst we", {31'b0, wb_we_o}, 32'd0);
    chk("rst sel", {28'b0, wb_sel_o}, 32'd0);
    chk("rst adr", wb_adr_o, 32'd0);
    chk("rst dat", wb_dat_o, 32'd0);
    chk("rst irq", {31'b0, irq}, 32'd0);
    chk("rst csr_do", csr_do, 32'd0);
    sys_rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      csr_rd(10'(r), rv);
      chk($sformatf("rst reg%0d", r), rv, 32'd0);
    end

    // CSR field masks and unmapped registers
    for (int i = 0; i < 9; i++) begin
      csr_wr(tbl[i].r, tbl[i].wd);
      csr_rd(tbl[i].r, rv);
      chk($sformatf("csr vec%0d", i), rv, tbl[i].exp);
    end

    // Bank select
    csr_wr(CSR_SRC, 32'hABCD0000);
    @(negedge sys_clk);
    csr_a = {4'h0, CSR_SRC}; csr_di = 32'h11110000; csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
    @(negedge sys_clk);
    chk("other bank read", csr_do, 32'd0);
    csr_rd(CSR_SRC, rv);
    chk("other bank write ignored", rv, 32'hABCD0000);

    // LEN=4 basic copy with timing
    for (int k = 0; k < 4; k++) mem[32'h1000 + 32'(4 * k)] = 32'hA0 + 32'(k);
    start_xfer(32'h1000, 32'h2000, 4, 0);
    first_stb = -1; irq_at = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge sys_clk);
      if (wb_stb_o && first_stb < 0) first_stb = c;
      if (irq) begin irq_at = c; break; end
    end
    chk("basic first stb cycle", first_stb, 1);
    chk("basic irq cycle", irq_at, 24);
    chk("basic log size", 32'(log_adr.size()), 32'd8);
    for (int k = 0; k < 4 && log_adr.size() == 8; k++) begin
      chk($sformatf("basic rd adr%0d", k), log_adr[2 * k], 32'h1000 + 32'(4 * k));
      chk($sformatf("basic wr adr%0d", k), log_adr[2 * k + 1], 32'h2000 + 32'(4 * k));
      chk($sformatf("basic dst%0d", k), rd_mem(32'h2000 + 32'(4 * k)), 32'hA0 + 32'(k));
      if (k > 0) chk($sformatf("basic word%0d cycles", k), log_cyc[2 * k] - log_cyc[2 * k - 2], 6);
    end
    csr_rd(CSR_STAT, rv);
    chk("basic stat", rv, 32'h1);
    chk("basic irq", {31'b0, irq}, 32'd1);

    // LEN=0
    csr_wr(CSR_STAT, 32'h5);
    chk("w1c event_end", {31'b0, irq}, 32'd0);
    csr_wr(CSR_LEN, 32'd0);
    stb_cycles = 0;
    csr_wr(CSR_CTRL, 32'h3);
    @(negedge sys_clk);
    chk("len0 irq", {31'b0, irq}, 32'd1);
    repeat (10) @(negedge sys_clk);
    chk("len0 no stb", 32'(stb_cycles), 32'd0);
    csr_rd(CSR_STAT, rv);
    chk("len0 stat", rv, 32'h1);

    // Wait states, with writes and start attempted while busy
    fill(32'h3000, 5);
    prep_model(32'h3000, 32'h3800, 5);
    early_drop = 0;
    start_xfer(32'h3000, 32'h3800, 5, 3);
    repeat (3) @(negedge sys_clk);
    csr_wr(CSR_SRC, 32'h0);
    csr_wr(CSR_LEN, 32'd1);
    csr_wr(CSR_CTRL, 32'h3);
    wait_idle("ws3");
    cmp_run("ws3", 32'h3800, 5);
    chk("ws3 stb held", 32'(early_drop), 32'd0);
    csr_rd(CSR_SRC, rv);
    chk("ws3 src kept", rv, 32'h3000);
    csr_rd(CSR_LEN, rv);
    chk("ws3 len kept", rv, 32'd5);

    // Abort during RD of word 2 of 8
    fill(32'h5000, 8);
    fill(32'h5800, 8);
    prep_model(32'h5000, 32'h5800, 3);
    start_xfer(32'h5000, 32'h5800, 8, 0);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge sys_clk);
      if (log_adr.size() == 4 && wb_stb_o && !wb_we_o) found = 1'b1;
    end
    chk("abort reached word2", {31'b0, found}, 32'd1);
    csr_a = {BANK, CSR_CTRL}; csr_di = 32'h5; csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
    wait_idle("abort");
    cmp_run("abort", 32'h5800, 8);
    csr_rd(CSR_STAT, rv);
    chk("abort stat", rv, 32'h5);
    csr_wr(CSR_STAT, 32'h4);
    csr_rd(CSR_STAT, rv);
    chk("abort w1c", rv, 32'h1);

    // Address wrap
    prep_model(32'hFFFFFFFC, 32'h6000, 2);
    start_xfer(32'hFFFFFFFC, 32'h6000, 2, 0);
    wait_idle("wrap");
    cmp_run("wrap", 32'h6000, 2);
    if (log_adr.size() > 2) chk("wrap second rd", log_adr[2], 32'h0);
    else chk("wrap second rd present", 32'(log_adr.size()), 32'd4);

    // Randomized copies in a shared region
    for (int it = 0; it < 6; it++) begin
      fill(32'h4000, 80);
      s = 32'h4000 + 32'(4 * $urandom_range(0, 63));
      d = 32'h4000 + 32'(4 * $urandom_range(0, 63));
      n = $urandom_range(1, 12);
      w = $urandom_range(0, 2);
      prep_model(s, d, n);
      start_xfer(s, d, n, w);
      wait_idle($sformatf("rnd%0d", it));
      cmp_run($sformatf("rnd%0d", it), d, n);
      csr_rd(CSR_STAT, rv);
      chk($sformatf("rnd%0d stat", it), rv, 32'h1);
    end

    // Asynchronous reset mid-WR
    start_xfer(32'h7000, 32'h7800, 4, 3);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge sys_clk);
      if (wb_stb_o && wb_we_o) found = 1'b1;
    end
    chk("rst reached WR", {31'b0, found}, 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    chk("async rst stb", {31'b0, wb_stb_o}, 32'd0);
    chk("async rst cyc", {31'b0, wb_cyc_o}, 32'd0);
    chk("async rst we", {31'b0, wb_we_o}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      csr_rd(10'(r), rv);
      chk($sformatf("post rst reg%0d", r), rv, 32'd0);
    end
    chk("post rst irq", {31'b0, irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
